// File: rtl/mem_pkg.sv
// Shared types and March C- element tables for the memory march master.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_RD,
        ST_WAIT_RD,
        ST_REQ_WR,
        ST_WAIT_WR,
        ST_NEXT,
        ST_FINISH
    } mem_march_state_t;

    typedef enum logic [1:0] {
        EL_E0,
        EL_E1,
        EL_E2,
        EL_E3
    } mem_march_elem_t;

    localparam mem_march_elem_t LAST_ELEM = EL_E3;

    // One bit per element, bit index = element number.
    localparam logic [3:0] ELEM_DOWN   = 4'b0100;
    localparam logic [3:0] ELEM_HAS_RD = 4'b1110;
    localparam logic [3:0] ELEM_HAS_WR = 4'b0111;
    localparam logic [3:0] ELEM_RD_INV = 4'b0100;
    localparam logic [3:0] ELEM_WR_INV = 4'b0010;

    function automatic logic elem_down(input mem_march_elem_t e);
        return ELEM_DOWN[e];
    endfunction

    function automatic logic elem_has_wr(input mem_march_elem_t e);
        return ELEM_HAS_WR[e];
    endfunction

    function automatic logic elem_rd_inv(input mem_march_elem_t e);
        return ELEM_RD_INV[e];
    endfunction

    function automatic logic elem_wr_inv(input mem_march_elem_t e);
        return ELEM_WR_INV[e];
    endfunction

    function automatic mem_march_state_t elem_first_req(input mem_march_elem_t e);
        return ELEM_HAS_RD[e] ? ST_REQ_RD : ST_REQ_WR;
    endfunction

endpackage

// File: rtl/mem_march_addr_gen.sv
// Loadable up/down address counter; stops at the last address of its run.
module mem_march_addr_gen
    import mem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  is_last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  down_q, down_d;

    assign addr    = addr_q;
    assign is_last = down_q ? (addr_q == '0) : (addr_q == ADDR_MAX);

    always_comb begin
        addr_d = addr_q;
        down_d = down_q;
        if (load) begin
            down_d = load_down;
            addr_d = load_down ? ADDR_MAX : '0;
        end else if (step && !is_last) begin
            addr_d = down_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            down_q <= down_d;
        end
    end

endmodule

// File: rtl/mem_march_master.sv
// March C- request master: drives a valid/ready memory port and checks every read.
//
//   state      | meaning
//   IDLE       | waiting for start; results held
//   REQ_RD     | first cycle of a read request (valid high)
//   WAIT_RD    | read request held until ready
//   REQ_WR     | first cycle of a write request (valid high)
//   WAIT_WR    | write request held until ready
//   NEXT       | element finished: load next element or finish
//   FINISH     | done asserted, back to IDLE
module mem_march_master
    import mem_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      pattern,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic                  ready,
    input  logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);

    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);

    mem_march_state_t      state_q, state_d;
    mem_march_elem_t       elem_q, elem_d;
    logic [WIDTH-1:0]      pattern_q, pattern_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;
    logic [ADDR_WIDTH-1:0] first_fail_addr_q, first_fail_addr_d;

    logic                  ag_load, ag_load_down, ag_step, ag_last;
    logic                  advance;
    logic [WIDTH-1:0]      rd_expect;

    mem_march_addr_gen #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .addr      (addr),
        .is_last   (ag_last)
    );

    // Request outputs decode straight from state so they cannot move while a request waits.
    assign valid = (state_q == ST_REQ_RD) || (state_q == ST_WAIT_RD) ||
                   (state_q == ST_REQ_WR) || (state_q == ST_WAIT_WR);
    assign wr_rd = (state_q == ST_REQ_WR) || (state_q == ST_WAIT_WR);
    assign wdata     = elem_wr_inv(elem_q) ? ~pattern_q : pattern_q;
    assign rd_expect = elem_rd_inv(elem_q) ? ~pattern_q : pattern_q;

    assign busy            = busy_q;
    assign done            = done_q;
    assign fail            = fail_q;
    assign err_count       = err_count_q;
    assign first_fail_addr = first_fail_addr_q;

    always_comb begin
        state_d           = state_q;
        elem_d            = elem_q;
        pattern_d         = pattern_q;
        busy_d            = busy_q;
        done_d            = done_q;
        fail_d            = fail_q;
        err_count_d       = err_count_q;
        first_fail_addr_d = first_fail_addr_q;
        ag_load           = 1'b0;
        ag_load_down      = 1'b0;
        ag_step           = 1'b0;
        advance           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    pattern_d         = pattern;
                    busy_d            = 1'b1;
                    done_d            = 1'b0;
                    fail_d            = 1'b0;
                    err_count_d       = '0;
                    first_fail_addr_d = '0;
                    elem_d            = EL_E0;
                    ag_load           = 1'b1;
                    ag_load_down      = elem_down(EL_E0);
                    state_d           = elem_first_req(EL_E0);
                end
            end
            ST_REQ_RD, ST_WAIT_RD: begin
                state_d = ST_WAIT_RD;
                if (ready) begin
                    if (rdata != rd_expect) begin
                        fail_d = 1'b1;
                        if (err_count_q != ERR_MAX) begin
                            err_count_d = err_count_q + ERR_ONE;
                        end
                        if (!fail_q) begin
                            first_fail_addr_d = addr;
                        end
                    end
                    if (elem_has_wr(elem_q)) begin
                        state_d = ST_REQ_WR;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_REQ_WR, ST_WAIT_WR: begin
                state_d = ST_WAIT_WR;
                if (ready) begin
                    advance = 1'b1;
                end
            end
            ST_NEXT: begin
                if (elem_q == LAST_ELEM) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    elem_d       = mem_march_elem_t'(elem_q + 2'd1);
                    ag_load      = 1'b1;
                    ag_load_down = elem_down(elem_d);
                    state_d      = elem_first_req(elem_d);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stepping within an element skips NEXT so back-to-back accesses cost two cycles.
        if (advance) begin
            if (ag_last) begin
                state_d = ST_NEXT;
            end else begin
                ag_step = 1'b1;
                state_d = elem_first_req(elem_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            elem_q            <= EL_E0;
            pattern_q         <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            fail_q            <= 1'b0;
            err_count_q       <= '0;
            first_fail_addr_q <= '0;
        end else begin
            state_q           <= state_d;
            elem_q            <= elem_d;
            pattern_q         <= pattern_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            fail_q            <= fail_d;
            err_count_q       <= err_count_d;
            first_fail_addr_q <= first_fail_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_march_master.sv
// Bench for mem_march_master: faulty memory model, variable ready latency, March reference model.
module tb_mem_march_master;

    localparam int W   = 16;
    localparam int D   = 64;
    localparam int AW  = 6;
    localparam int DS  = 128;
    localparam int AWS = 7;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic          valid, wr_rd, ready, busy, done, fail;
    logic [AW-1:0] addr, first_fail_addr;
    logic [W-1:0]  wdata, rdata;
    logic [7:0]    err_count;

    logic           start_s = 1'b0;
    logic [W-1:0]   pattern_s = 16'hA5A5;
    logic           valid_s, wr_rd_s, ready_s, busy_s, done_s, fail_s;
    logic [AWS-1:0] addr_s, first_fail_addr_s;
    logic [W-1:0]   wdata_s;
    logic [7:0]     err_count_s;

    mem_march_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .ERR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .busy(busy), .done(done), .fail(fail),
        .err_count(err_count), .first_fail_addr(first_fail_addr)
    );

    mem_march_master #(.WIDTH(W), .DEPTH(DS), .ADDR_WIDTH(AWS), .ERR_WIDTH(8)) dut_sat (
        .clk(clk), .rst(rst), .start(start_s), .pattern(pattern_s),
        .valid(valid_s), .wr_rd(wr_rd_s), .addr(addr_s), .wdata(wdata_s),
        .ready(ready_s), .rdata(16'h0000), .busy(busy_s), .done(done_s), .fail(fail_s),
        .err_count(err_count_s), .first_fail_addr(first_fail_addr_s)
    );

    // Memory model with per-address stuck-at masks applied on read
    logic [W-1:0] mem      [D];
    logic [W-1:0] and_mask [D];
    logic [W-1:0] or_mask  [D];

    assign rdata = (mem[addr] & and_mask[addr]) | or_mask[addr];

    always @(posedge clk) begin
        if (!rst && valid && ready && wr_rd) mem[addr] <= wdata;
    end

    // Ready generator: ready rises cur_lat cycles after valid, optional noise while idle
    int lat_min = 1, lat_max = 1;
    bit noise_en = 1'b0;
    int wait_cnt = 0, cur_lat = 1;

    always @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b0;
            wait_cnt <= 0;
        end else if (valid && ready) begin
            ready    <= 1'b0;
            wait_cnt <= 0;
            cur_lat  <= $urandom_range(lat_max, lat_min);
        end else if (valid) begin
            if (wait_cnt + 1 >= cur_lat) ready <= 1'b1;
            wait_cnt <= wait_cnt + 1;
        end else begin
            ready    <= noise_en ? 1'($urandom_range(1, 0)) : 1'b0;
            wait_cnt <= 0;
        end
    end

    always @(posedge clk) begin
        ready_s <= rst ? 1'b0 : (valid_s && !ready_s);
    end

    // Expected access sequence and results, filled by the reference model
    op_t exp_ops [6*D];
    int  exp_n = 0, exp_err = 0, exp_ffa = 0;
    bit  exp_fail = 1'b0;

    // Handshake monitor: order/content against exp_ops, stability while waiting
    int hs_count = 0, mon_err = 0, stab_err = 0;
    int hs_base = 0, mon_base = 0, stab_base = 0;
    logic        pend = 1'b0;
    logic [22:0] held = '0;

    always @(negedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (pend && (!valid || {wr_rd, addr, wdata} != held)) stab_err <= stab_err + 1;
            pend <= valid && !ready;
            held <= {wr_rd, addr, wdata};
            if (valid && ready) begin
                hs_count <= hs_count + 1;
                if ((hs_count - hs_base) >= exp_n)
                    mon_err <= mon_err + 1;
                else if (exp_ops[hs_count - hs_base].wr !== wr_rd ||
                         exp_ops[hs_count - hs_base].a  !== addr  ||
                         (wr_rd && exp_ops[hs_count - hs_base].d !== wdata))
                    mon_err <= mon_err + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_masks();
        for (int i = 0; i < D; i++) begin
            and_mask[i] = '1;
            or_mask[i]  = '0;
        end
    endtask

    // March C-: E0 up W(P); E1 up R(P) W(~P); E2 down R(~P) W(P); E3 up R(P)
    task automatic ref_model(input logic [W-1:0] p);
        logic [W-1:0] m [D];
        logic [W-1:0] e, v;
        int a;
        exp_n = 0; exp_err = 0; exp_ffa = 0; exp_fail = 1'b0;
        for (int el = 0; el < 4; el++) begin
            for (int k = 0; k < D; k++) begin
                a = (el == 2) ? (D - 1 - k) : k;
                if (el != 0) begin
                    e = (el == 2) ? ~p : p;
                    v = (m[a] & and_mask[a]) | or_mask[a];
                    exp_ops[exp_n] = '{wr: 1'b0, a: AW'(a), d: e};
                    exp_n++;
                    if (v !== e) begin
                        if (!exp_fail) exp_ffa = a;
                        exp_fail = 1'b1;
                        if (exp_err < 255) exp_err++;
                    end
                end
                if (el != 3) begin
                    e = (el == 1) ? ~p : p;
                    m[a] = e;
                    exp_ops[exp_n] = '{wr: 1'b1, a: AW'(a), d: e};
                    exp_n++;
                end
            end
        end
    endtask

    // Starts a test with pattern p and waits up to budget cycles for done.
    // cycles = edges from the accepting edge to done, or budget+1 on timeout.
    task automatic run_test(input logic [W-1:0] p, input int mid_start, input int budget,
                            output int cycles);
        ref_model(p);
        @(negedge clk);
        pattern = p;
        start   = 1'b1;
        @(posedge clk);
        hs_base   = hs_count;
        mon_base  = mon_err;
        stab_base = stab_err;
        @(negedge clk);
        start   = 1'b0;
        pattern = W'($urandom);
        cycles  = budget + 1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            start = (n == mid_start);
            if (n == mid_start) pattern = ~p;
            if (done === 1'b1) begin
                cycles = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fail"}, fail, exp_fail);
        chk({tag, "_err"}, err_count, exp_err);
        chk({tag, "_ffa"}, first_fail_addr, exp_ffa);
        chk({tag, "_hs"}, hs_count - hs_base, exp_n);
        chk({tag, "_seq"}, mon_err - mon_base, 0);
        chk({tag, "_stable"}, stab_err - stab_base, 0);
    endtask

    initial begin
        int cyc;
        int h0;
        int fa, fb;
        logic [W-1:0] p, bitm;

        clear_masks();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_wr_rd", wr_rd, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ffa", first_fail_addr, 0);
        rst = 1'b0;

        // Clean memory, 1-cycle ready
        lat_min = 1; lat_max = 1;
        run_test(16'hA5A5, 0, 2000, cyc);
        check_result("clean");
        chk("clean_latency_ok", cyc <= 12*D + 4, 1);
        chk("clean_final_addr", addr, D - 1);

        // Bit 3 of address 10 stuck at 0
        and_mask[10] = ~16'h0008;
        run_test(16'hA5A5, 0, 2000, cyc);
        check_result("stuck");

        // ready held off 3 cycles on every request, random pattern
        clear_masks();
        lat_min = 3; lat_max = 3;
        p = W'($urandom);
        run_test(p, 0, 3000, cyc);
        check_result("lat3");

        // Reset 100 cycles into a run aborts it
        lat_min = 1; lat_max = 1;
        run_test(W'($urandom), 0, 100, cyc);
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err_count, 0);
        h0 = hs_count;
        repeat (5) @(negedge clk);
        chk("abort_no_hs", hs_count - h0, 0);
        chk("abort_idle_valid", valid, 0);
        lat_min = 1; lat_max = 2;
        run_test(W'($urandom), 0, 3000, cyc);
        check_result("after_abort");

        // Random single stuck bit, random latency with idle ready noise, start while busy
        fa   = $urandom_range(D - 1, 0);
        fb   = $urandom_range(W - 1, 0);
        bitm = 16'h0001 << fb;
        if ($urandom_range(1, 0) == 1) and_mask[fa] = ~bitm;
        else                           or_mask[fa]  = bitm;
        lat_min = 1; lat_max = 3; noise_en = 1'b1;
        p = W'($urandom);
        run_test(p, 40, 3000, cyc);
        check_result("busy_start");
        noise_en = 1'b0;
        clear_masks();

        // DEPTH=128 against an all-zero memory: error counter saturates
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int n = 0; n < 12*DS + 50 && done_s !== 1'b1; n++) @(negedge clk);
        chk("sat_done", done_s, 1);
        chk("sat_busy", busy_s, 0);
        chk("sat_fail", fail_s, 1);
        chk("sat_err", err_count_s, 255);
        chk("sat_ffa", first_fail_addr_s, 0);
        chk("sat_last_addr", addr_s, DS - 1);
        chk("sat_idle_wr_rd", wr_rd_s, 0);
        chk("sat_idle_valid", valid_s, 0);
        chk("sat_wdata", wdata_s, 16'hA5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_march_master.md
Name: mem_march_master

Overview:
- Request-side stage that drives the memory slave's valid/ready port with a March C- style test sequence.
- Checks every read against the expected pattern and reports pass/fail, error count and first failing address.
- Sits directly upstream of the memory and shares its valid, wr_rd, addr, wdata, rdata and ready signals.
- Used for power-on memory self-test and as a self-checking stimulus source in the memory bench.

Parameters:
- WIDTH, 16, data width; must match the memory.
- DEPTH, 64, number of words tested.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a test when not busy.
- pattern  input  WIDTH  background word; latched on an accepted start.
- valid  output  1  request valid to the memory.
- wr_rd  output  1  1 = write, 0 = read.
- addr  output  ADDR_WIDTH  request address.
- wdata  output  WIDTH  write data.
- ready  input  1  memory accepts the request; a transfer occurs on any cycle with valid && ready.
- rdata  input  WIDTH  read data, sampled on the read handshake cycle.
- busy  output  1  test in progress.
- done  output  1  sticky; test complete.
- fail  output  1  sticky; at least one miscompare.
- err_count  output  ERR_WIDTH  saturating miscompare count.
- first_fail_addr  output  ADDR_WIDTH  address of the first miscompare.

Behaviour:
- Reset, sampled on a clk edge with rst=1: valid=0, wr_rd=0, addr=0, wdata=0, busy=0, done=0, fail=0, err_count=0, first_fail_addr=0, FSM to IDLE. Reset mid-test aborts the test immediately; no further requests are issued.
- wdata is never X: it is driven from the latched pattern or its complement at all times after reset.
- Handshake rules:
  - Once valid rises, valid, wr_rd, addr and wdata stay stable until the cycle where ready=1.
  - valid drops, or the next request is presented, on the cycle after the handshake.
  - Any ready latency of 1 or more cycles is tolerated.
  - ready while valid=0 is ignored.
- Elements, with P = latched pattern and ~P its complement:
  - E0 W(P), ascending.
  - E1 R(P) then W(~P), ascending.
  - E2 R(~P) then W(P), descending.
  - E3 R(P), ascending.
  - In E1 and E2, the read and write to the same address are back-to-back before the address advances.
- Address sequencing:
  - Ascending runs 0..DEPTH-1; descending runs DEPTH-1..0.
  - An element ends on its last address; there is no wrap-around and no underflow past 0.
- FSM states: IDLE, REQ_RD, WAIT_RD, REQ_WR, WAIT_WR, NEXT, FINISH.
  - IDLE: on start && !busy, latch pattern, clear done/fail/err_count/first_fail_addr, set busy, go to the first request state of E0.
  - REQ_*: assert valid, then go to WAIT_*.
  - WAIT_*: on ready, complete the transfer, then go to the write state (R-then-W elements) or NEXT.
  - NEXT: on the last address of the last element go to FINISH; otherwise step the address, or load the next element's start address.
  - FINISH: busy=0, done=1, return to IDLE.
  - Starting a new test clears done.
- Read compare: on a read handshake, if rdata != expected then fail=1 and err_count increments, saturating at 2^ERR_WIDTH-1. first_fail_addr is written only on the first miscompare of a test.
- start while busy is ignored. start in the same cycle as rst is ignored.
- Latency: with a 1-cycle ready, each access takes 2 cycles. 6*DEPTH accesses give done asserted at most 12*DEPTH+4 cycles after start.

Decomposition:
- mem_pkg holds:
  - state enum (mem_march_state_t);
  - element enum (E0..E3);
  - per-element constant tables: direction, has_read, has_write, read expects ~P, write uses ~P.
- One sub-module, mem_march_addr_gen: loadable up/down address counter with a first/last flag, parameterised by ADDR_WIDTH and DEPTH.

Test Plan:
- Clean model memory, 1-cycle ready, pattern=16'hA5A5, DEPTH=64 -> exactly 384 handshakes, done=1 within 772 cycles, fail=0, err_count=0.
- Model bit 3 of address 10 stuck at 0, pattern=16'hA5A5 -> only the E2 read at addr 10 miscompares; fail=1, err_count=1, first_fail_addr=10.
- ready delayed 3 cycles on every request -> valid/addr/wdata held stable throughout each wait, no extra handshakes, same result as the clean run.
- rst pulsed at cycle 100 of a run -> next cycle valid=0, busy=0, done=0, err_count=0. A subsequent start completes cleanly with done=1.
- start pulsed during busy -> ignored, pattern not relatched. E2 address trace is 63,63,62,62..0,0 with no access to 63 after 0.
- DEPTH=128, memory stuck at all-zero, pattern=16'hA5A5 -> err_count saturates at 255, first_fail_addr=0, fail=1, done=1.
